mxrv_div: RTL and testbench

Multi-cycle RV32M divider that executes DIV, DIVU, REM and REMU for the execute stage. It is started by the execute stage and drives the busy signal the execute stage uses to suppress register write-back. It returns the quotient or remainder, plus the destination register address, as a one-cycle ready pulse. It uses a radix-2 restoring algorithm on magnitudes, with sign correction at the end.

---
 rtl/mxrv_div.sv | 182 ++++++++++++++++++
 tb/tb_mxrv_div.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mxrv_div.sv
// RV32M divider (DIV/DIVU/REM/REMU): radix-2 restoring on magnitudes, sign fix-up at the end.
// Latency: 33 cycles start-to-ready; with MXRV_DIV_EARLY_OUT_EN, divide-by-zero/signed overflow take 1 cycle.
// Backpressure: none; start_i is ignored unless IDLE, ready_o is a one-cycle pulse, flush_i aborts silently.
module mxrv_div #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [2:0]            op_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [DATA_W-1:0]     result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [DATA_W-1:0] ONE_W = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     rem_q;
    logic [DATA_W-1:0]     quo_q;
    logic [DATA_W-1:0]     dvs_q;
    logic                  neg_quo_q;
    logic                  neg_rem_q;
    logic                  rem_sel_q;
    logic                  div_zero_q;
    logic [REG_ADDR_W-1:0] rd_q;

    // funct3 bit 2 is always set for the divide group; the op is fully decoded by bits 1:0.
    logic unused_op;
    assign unused_op = op_i[2];

    logic              op_signed;
    logic              op_rem;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic              div_zero_in;

    // Operand decode: magnitudes for signed ops (MIN maps to itself, read as unsigned).
    always_comb begin
        op_signed   = ~op_i[0];
        op_rem      = op_i[1];
        a_neg       = op_signed & dividend_i[DATA_W-1];
        b_neg       = op_signed & divisor_i[DATA_W-1];
        a_mag       = a_neg ? (~dividend_i + ONE_W) : dividend_i;
        b_mag       = b_neg ? (~divisor_i + ONE_W) : divisor_i;
        div_zero_in = (divisor_i == '0);
    end

`ifdef MXRV_DIV_EARLY_OUT_EN
    logic              ovf_in;
    logic              early_in;
    logic [DATA_W-1:0] early_res;

    // Special cases resolved straight from the inputs so they can skip the iteration loop.
    always_comb begin
        ovf_in    = op_signed
                    && (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                    && (divisor_i == '1);
        early_in  = div_zero_in | ovf_in;
        early_res = '0;
        if (div_zero_in) begin
            early_res = op_rem ? dividend_i : '1;
        end else begin
            early_res = op_rem ? '0 : dividend_i;
        end
    end
`endif

    logic [DATA_W:0]   rem_sh;
    logic              rem_ge;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;
    logic [DATA_W-1:0] final_res;

    // One restoring step plus the sign/special-case fix-up used on the last iteration.
    // The compare is one bit wider than the data so the bit shifted out of rem is not lost.
    always_comb begin
        rem_sh = {rem_q, quo_q[DATA_W-1]};
        rem_ge = (rem_sh >= {1'b0, dvs_q});
        rem_nx = rem_ge ? (rem_sh[DATA_W-1:0] - dvs_q) : rem_sh[DATA_W-1:0];
        quo_nx = {quo_q[DATA_W-2:0], rem_ge};

        quo_fix = neg_quo_q ? (~quo_nx + ONE_W) : quo_nx;
        if (div_zero_q) begin
            quo_fix = '1;
        end
        rem_fix   = neg_rem_q ? (~rem_nx + ONE_W) : rem_nx;
        final_res = rem_sel_q ? rem_fix : quo_fix;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            div_zero_q <= 1'b0;
            rd_q       <= '0;
            busy_o     <= 1'b0;
            ready_o    <= 1'b0;
            result_o   <= '0;
            rd_addr_o  <= '0;
        end else begin
            ready_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i && !flush_i) begin
                        rem_q      <= '0;
                        quo_q      <= a_mag;
                        dvs_q      <= b_mag;
                        neg_quo_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        rem_sel_q  <= op_rem;
                        div_zero_q <= div_zero_in;
                        rd_q       <= rd_addr_i;
                        cnt        <= CNT_W'(DATA_W - 1);
                        state      <= S_CALC;
                        busy_o     <= 1'b1;
`ifdef MXRV_DIV_EARLY_OUT_EN
                        if (early_in) begin
                            state     <= S_DONE;
                            busy_o    <= 1'b0;
                            ready_o   <= 1'b1;
                            result_o  <= early_res;
                            rd_addr_o <= rd_addr_i;
                        end
`endif
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        if (cnt == '0) begin
                            state     <= S_DONE;
                            busy_o    <= 1'b0;
                            ready_o   <= 1'b1;
                            result_o  <= final_res;
                            rd_addr_o <= rd_q;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxrv_div.sv
// Self-checking bench for mxrv_div: directed vectors feed a scoreboard queue,
// a negedge monitor pops and compares on every ready_o pulse.
// Latency expectations follow MXRV_DIV_EARLY_OUT_EN when the bench is built with it.
module tb_mxrv_div;

`ifdef MXRV_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    mxrv_div #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ready_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready actual=ready_o=1 result=%h rd=%0d required=no pulse (cycle %0d)",
                             result_o, rd_addr_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result_o, e.res);
                    chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.rd});
                    chk("latency", cyc - e.t0 + 1, e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input logic [31:0] res,
                         input bit early);
        exp_t e;
        @(negedge clk);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        @(posedge clk);
        #1;
        if (push) begin
            e.res = res;
            e.rd  = rd;
            e.lat = (EARLY && early) ? 1 : 33;
            e.t0  = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic [31:0] res, input bit early);
        int n = 0;
        issue(op, a, b, rd, 1'b1, res, early);
        for (int i = 0; i < 100; i++) begin
            if (ready_o) break;
            if (busy_o) n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, (EARLY && early) ? 0 : 32);
        last_res = res;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_ready", {31'd0, ready_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //      op       dividend      divisor       rd  expected      special
        run_vec(OP_DIVU, 32'd100,      32'd7,        5,  32'd14,       1'b0);
        run_vec(OP_REM,  32'hFFFFFFF9, 32'd2,        1,  32'hFFFFFFFF, 1'b0);
        run_vec(OP_DIV,  32'hFFFFFFF9, 32'd2,        2,  32'hFFFFFFFD, 1'b0);
        run_vec(OP_DIV,  32'd5,        32'd0,        3,  32'hFFFFFFFF, 1'b1);
        run_vec(OP_REMU, 32'd5,        32'd0,        4,  32'd5,        1'b1);
        run_vec(OP_DIV,  32'hFFFFFFF9, 32'd0,        16, 32'hFFFFFFFF, 1'b1);
        run_vec(OP_REM,  32'hFFFFFFF9, 32'd0,        17, 32'hFFFFFFF9, 1'b1);
        run_vec(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 6,  32'h80000000, 1'b1);
        run_vec(OP_REM,  32'h80000000, 32'hFFFFFFFF, 7,  32'd0,        1'b1);
        run_vec(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 18, 32'd0,        1'b0);
        run_vec(OP_REMU, 32'h80000000, 32'hFFFFFFFF, 19, 32'h80000000, 1'b0);
        run_vec(OP_DIV,  32'd7,        32'hFFFFFFFE, 20, 32'hFFFFFFFD, 1'b0);
        run_vec(OP_REM,  32'd7,        32'hFFFFFFFE, 21, 32'd1,        1'b0);
        run_vec(OP_DIVU, 32'hFFFFFFFF, 32'd1,        22, 32'hFFFFFFFF, 1'b0);
        run_vec(OP_REMU, 32'hFFFFFFFF, 32'h10,       23, 32'hF,        1'b0);
        run_vec(OP_DIV,  32'h80000000, 32'd2,        24, 32'hC0000000, 1'b0);

        // Start pulses while busy must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd3, 10, 1'b1, 32'd333, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_i    = 1'b1;
            op_i       = OP_DIV;
            dividend_i = 32'd50;
            divisor_i  = 32'd5;
            rd_addr_i  = 5'd11;
            @(negedge clk);
            start_i = 1'b0;
        end
        wait_idle();
        last_res = 32'd333;

        // Flush mid-operation: no ready, result holds, next start accepted.
        issue(OP_DIVU, 32'd1000, 32'd3, 12, 1'b0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_busy", {31'd0, busy_o}, 32'd0);
        chk("flush_ready", {31'd0, ready_o}, 32'd0);
        chk("flush_result_hold", result_o, last_res);
        @(negedge clk);
        flush_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("flush_result_still", result_o, last_res);
        run_vec(OP_DIVU, 32'd9, 32'd3, 13, 32'd3, 1'b0);

        // Reset mid-operation clears every output.
        issue(OP_DIVU, 32'd1000, 32'd3, 14, 1'b0, 32'd0, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", {31'd0, busy_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_rd", {27'd0, rd_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_result_still", result_o, 32'd0);
        run_vec(OP_DIVU, 32'd9, 32'd3, 15, 32'd3, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
